// File: rtl/mod_tick_counter.sv
// Modulo-MODULUS up/down step counter paced by a PRESCALE-cycle enabled prescaler.
// Latency: count/done/halted are registered and change on the clock edge that takes the step.
// Backpressure: none; enable=0 freezes the prescaler and count, and a one-shot halt blocks steps until clear/load.
//
// Ports:
//   clock, resetn      rising-edge clock, asynchronous active-low reset
//   enable             advance prescaler/counter
//   clear, load        synchronous clear / load of load_value (clear wins)
//   load_value         load value, clamped to MODULUS-1
//   up                 count direction, sampled on each step
//   oneshot            1 = stop at terminal value, 0 = wrap
//   count              current count, always within 0..MODULUS-1
//   done               one-cycle pulse: the last step landed on the terminal value
//   halted             one-shot counting has stopped at the terminal value
module mod_tick_counter #(
    parameter int WIDTH    = 3,
    parameter int MODULUS  = 5,
    parameter int PRESCALE = 1,
    parameter int PS_W     = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             enable,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             up,
    input  logic             oneshot,
    output logic [WIDTH-1:0] count,
    output logic             done,
    output logic             halted
);

    localparam logic [WIDTH-1:0] CNT_TOP = WIDTH'(MODULUS - 1);
    localparam logic [PS_W-1:0]  PS_TOP  = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]  ps;
    logic             step;
    logic [WIDTH-1:0] stepped;
    logic [WIDTH-1:0] terminal;
    logic             at_terminal;
    logic [WIDTH-1:0] load_clamped;

    // Next count for a step, the direction-dependent terminal value, and
    // whether the step lands on it.  Wrap is done here so no out-of-range
    // value ever reaches the count register.
    always_comb begin
        step     = enable && !halted && (ps == PS_TOP);
        terminal = up ? CNT_TOP : '0;
        stepped  = '0;
        if (up) begin
            stepped = (count == CNT_TOP) ? '0 : count + 1'b1;
        end else begin
            stepped = (count == '0) ? CNT_TOP : count - 1'b1;
        end
        at_terminal  = (stepped == terminal);
        load_clamped = (load_value > CNT_TOP) ? CNT_TOP : load_value;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count  <= '0;
            ps     <= '0;
            done   <= 1'b0;
            halted <= 1'b0;
        end else if (clear) begin
            count  <= '0;
            ps     <= '0;
            done   <= 1'b0;
            halted <= 1'b0;
        end else if (load) begin
            count  <= load_clamped;
            ps     <= '0;
            done   <= 1'b0;
            halted <= 1'b0;
        end else if (step) begin
            count  <= stepped;
            ps     <= '0;
            done   <= at_terminal;
            // A one-shot step that lands on terminal latches the halt;
            // only clear/load/reset release it.
            halted <= oneshot && at_terminal;
        end else begin
            done <= 1'b0;
            // While halted the prescaler is parked: its value is invisible
            // (every exit from halt zeroes it) and parking avoids overflow.
            if (enable && !halted) begin
                ps <= ps + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mod_tick_counter.sv
module tb_mod_tick_counter;

    logic       clock = 1'b0;
    logic       resetn;
    logic       enable;
    logic       clear;
    logic       load;
    logic [2:0] load_value;
    logic       up;
    logic       oneshot;

    logic [2:0] count1, count3;
    logic       done1, done3, halted1, halted3;

    int vectors     = 0;
    int miscompares = 0;

    // Scoreboards of expected {count, done, halted}, one per instance.
    logic [4:0] q1[$];
    logic [4:0] q3[$];

    mod_tick_counter #(.WIDTH(3), .MODULUS(5), .PRESCALE(1), .PS_W(8)) dut (
        .clock(clock), .resetn(resetn), .enable(enable), .clear(clear),
        .load(load), .load_value(load_value), .up(up), .oneshot(oneshot),
        .count(count1), .done(done1), .halted(halted1)
    );

    mod_tick_counter #(.WIDTH(3), .MODULUS(5), .PRESCALE(3), .PS_W(8)) dut3 (
        .clock(clock), .resetn(resetn), .enable(enable), .clear(clear),
        .load(load), .load_value(load_value), .up(up), .oneshot(oneshot),
        .count(count3), .done(done3), .halted(halted3)
    );

    always #5 clock = ~clock;

    task automatic cyc;
        @(posedge clock);
        #1;
    endtask

    task automatic exp1(input logic [2:0] c, input logic d, input logic h);
        q1.push_back({c, d, h});
    endtask

    task automatic exp3(input logic [2:0] c, input logic d, input logic h);
        q3.push_back({c, d, h});
    endtask

    task automatic chk1(input string tag);
        logic [4:0] o;
        logic [4:0] e;
        o = {count1, done1, halted1};
        vectors++;
        if (q1.size() == 0) begin
            miscompares++;
            $error("FAIL %s: no expected entry, observed count/done/halted=%b", tag, o);
        end else begin
            e = q1.pop_front();
            assert (o === e) else begin
                miscompares++;
                $error("FAIL %s: observed count/done/halted=%b expected %b", tag, o, e);
            end
        end
    endtask

    task automatic chk3(input string tag);
        logic [4:0] o;
        logic [4:0] e;
        o = {count3, done3, halted3};
        vectors++;
        if (q3.size() == 0) begin
            miscompares++;
            $error("FAIL %s: no expected entry, observed count/done/halted=%b", tag, o);
        end else begin
            e = q3.pop_front();
            assert (o === e) else begin
                miscompares++;
                $error("FAIL %s: observed count/done/halted=%b expected %b", tag, o, e);
            end
        end
    endtask

    initial begin
        logic [2:0] ps3_counts [11];
        ps3_counts = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3};

        resetn = 1'b0; enable = 1'b0; clear = 1'b0; load = 1'b0;
        load_value = 3'd0; up = 1'b1; oneshot = 1'b0;

        // Reset state
        #12;
        exp1(3'd0, 1'b0, 1'b0); chk1("reset_p1");
        exp3(3'd0, 1'b0, 1'b0); chk3("reset_p3");

        // Wrap counting up, PRESCALE=1: done high whenever count==4
        enable = 1'b1; resetn = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            exp1(3'(k % 5), (k % 5) == 4, 1'b0);
            cyc();
            chk1("wrap_up");
        end

        // PRESCALE=3: step every 3rd enabled cycle, enable=0 delays it by 2
        clear = 1'b1;
        exp3(3'd0, 1'b0, 1'b0); cyc(); chk3("ps3_clear");
        clear = 1'b0;
        for (int k = 0; k < 11; k++) begin
            enable = !(k == 4 || k == 5);
            exp3(ps3_counts[k], 1'b0, 1'b0);
            cyc();
            chk3("ps3_step");
        end
        enable = 1'b1;

        // Down counting through 0 and a clamped load
        clear = 1'b1; enable = 1'b0;
        exp1(3'd0, 1'b0, 1'b0); cyc(); chk1("dn_clear");
        clear = 1'b0; enable = 1'b1; up = 1'b1;
        exp1(3'd1, 1'b0, 1'b0); cyc(); chk1("dn_to1");
        up = 1'b0;
        exp1(3'd0, 1'b1, 1'b0); cyc(); chk1("dn_term");
        exp1(3'd4, 1'b0, 1'b0); cyc(); chk1("dn_wrap");
        exp1(3'd3, 1'b0, 1'b0); cyc(); chk1("dn_3");
        load = 1'b1; load_value = 3'd7;
        exp1(3'd4, 1'b0, 1'b0); cyc(); chk1("load_clamp");
        load = 1'b0;

        // One-shot: halt at 4, stay halted, clear restarts
        up = 1'b1; oneshot = 1'b1; clear = 1'b1;
        exp1(3'd0, 1'b0, 1'b0); cyc(); chk1("os_clear");
        clear = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            exp1(3'(k), 1'b0, 1'b0); cyc(); chk1("os_count");
        end
        exp1(3'd4, 1'b1, 1'b1); cyc(); chk1("os_term");
        for (int k = 0; k < 10; k++) begin
            if (k >= 7) oneshot = 1'b0;
            exp1(3'd4, 1'b0, 1'b1); cyc(); chk1("os_halted");
        end
        clear = 1'b1;
        exp1(3'd0, 1'b0, 1'b0); cyc(); chk1("os_release");
        clear = 1'b0;
        exp1(3'd1, 1'b0, 1'b0); cyc(); chk1("os_resume");

        // clear/load against a pending step
        exp1(3'd2, 1'b0, 1'b0); cyc(); chk1("pend_2");
        clear = 1'b1; load = 1'b1; load_value = 3'd3;
        exp1(3'd0, 1'b0, 1'b0); cyc(); chk1("clr_over_load");
        clear = 1'b0;
        exp1(3'd3, 1'b0, 1'b0); cyc(); chk1("load_over_step");
        load = 1'b0; oneshot = 1'b1;
        exp1(3'd4, 1'b1, 1'b1); cyc(); chk1("load_then_halt");
        exp1(3'd4, 1'b0, 1'b1); cyc(); chk1("halt_hold");

        // Asynchronous reset between edges, then restart
        #2 resetn = 1'b0;
        #1;
        exp1(3'd0, 1'b0, 1'b0); chk1("async_rst_p1");
        exp3(3'd0, 1'b0, 1'b0); chk3("async_rst_p3");
        #3 resetn = 1'b1; oneshot = 1'b0; up = 1'b1; enable = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            exp1(3'(k), 1'b0, 1'b0);
            exp3((k == 3) ? 3'd1 : 3'd0, 1'b0, 1'b0);
            cyc();
            chk1("rst_release_p1");
            chk3("rst_release_p3");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
